iob_axil2iob: RTL and testbench

//  AXI-Lite subordinate to IOb manager bridge. Lets an AXI-Lite initiator (CPU or interconnect) reach IOb peripherals.

---
 rtl/iob_axil2iob.sv | 221 ++++++++++++++++++++++
 tb/tb_iob_axil2iob.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axil2iob.sv
// AXI-Lite subordinate to IOb manager bridge: buffers AW/W/AR, issues one IOb
// transaction at a time and returns OKAY responses; read/write contention is round-robin.
module iob_axil2iob #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic [ADDR_W-1:0]     axil_awaddr_i,
    input  logic                  axil_awvalid_i,
    output logic                  axil_awready_o,
    input  logic [DATA_W-1:0]     axil_wdata_i,
    input  logic [DATA_W/8-1:0]   axil_wstrb_i,
    input  logic                  axil_wvalid_i,
    output logic                  axil_wready_o,
    output logic [1:0]            axil_bresp_o,
    output logic                  axil_bvalid_o,
    input  logic                  axil_bready_i,
    input  logic [ADDR_W-1:0]     axil_araddr_i,
    input  logic                  axil_arvalid_i,
    output logic                  axil_arready_o,
    output logic [DATA_W-1:0]     axil_rdata_o,
    output logic [1:0]            axil_rresp_o,
    output logic                  axil_rvalid_o,
    input  logic                  axil_rready_i,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    output logic                  iob_rready_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_RESP = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_aw_full;
    logic                r_w_full;
    logic                r_ar_full;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [ADDR_W-1:0]   r_ar_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic [STRB_W-1:0]   r_w_strb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_last_rd;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_wr_pend;
    logic                w_rd_pend;
    logic                w_grant_wr;
    logic                w_grant_rd;
    logic                w_wr_done;
    logic                w_rd_done;
    logic                w_rd_capture;

    assign w_aw_hs      = axil_awvalid_i & ~r_aw_full;
    assign w_w_hs       = axil_wvalid_i & ~r_w_full;
    assign w_ar_hs      = axil_arvalid_i & ~r_ar_full;
    assign w_wr_pend    = r_aw_full & r_w_full;
    assign w_rd_pend    = r_ar_full;
    assign w_wr_done    = (r_state == S_WR_REQ) & iob_ready_i;
    assign w_rd_done    = (r_state == S_RD_REQ) & iob_ready_i;
    assign w_rd_capture = (r_state == S_RD_WAIT) & iob_rvalid_i;

    // Arbitration in IDLE: a write wins when alone or when the last grant went to a read
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_wr_pend & (~w_rd_pend | r_last_rd)) begin
                w_grant_wr = 1'b1;
            end else if (w_rd_pend) begin
                w_grant_rd = 1'b1;
            end else begin
                w_grant_wr = 1'b0;
            end
        end else begin
            w_grant_rd = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = S_WR_REQ;
                end else if (w_grant_rd) begin
                    w_state_nxt = S_RD_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if (iob_ready_i) begin
                    w_state_nxt = S_WR_RESP;
                end else begin
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_RESP: begin
                if (axil_bready_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_RD_REQ: begin
                if (iob_ready_i) begin
                    w_state_nxt = S_RD_WAIT;
                end else begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                if (iob_rvalid_i) begin
                    w_state_nxt = S_RD_RESP;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_RESP: begin
                if (axil_rready_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RD_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and round-robin history
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state   <= S_IDLE;
            r_last_rd <= 1'b1;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
            if (w_grant_wr) begin
                r_last_rd <= 1'b0;
            end else if (w_grant_rd) begin
                r_last_rd <= 1'b1;
            end
        end
    end

    // Holding-register full flags: set on handshake, cleared once IOb accepts the request
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
        end else if (cke_i) begin
            if (w_wr_done) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_full <= 1'b1;
                if (w_w_hs)  r_w_full  <= 1'b1;
            end
            if (w_rd_done) begin
                r_ar_full <= 1'b0;
            end else if (w_ar_hs) begin
                r_ar_full <= 1'b1;
            end
        end
    end

    // Payload capture for AW, W, AR and returned read data
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_aw_addr <= '0;
            r_ar_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_rdata   <= '0;
        end else if (cke_i) begin
            if (w_aw_hs) r_aw_addr <= axil_awaddr_i;
            if (w_ar_hs) r_ar_addr <= axil_araddr_i;
            if (w_w_hs) begin
                r_w_data <= axil_wdata_i;
                r_w_strb <= axil_wstrb_i;
            end
            if (w_rd_capture) r_rdata <= iob_rdata_i;
        end
    end

    assign axil_awready_o = ~r_aw_full;
    assign axil_wready_o  = ~r_w_full;
    assign axil_arready_o = ~r_ar_full;
    assign axil_bvalid_o  = (r_state == S_WR_RESP);
    assign axil_bresp_o   = 2'b00;
    assign axil_rvalid_o  = (r_state == S_RD_RESP);
    assign axil_rresp_o   = 2'b00;
    assign axil_rdata_o   = r_rdata;

    // Read requests carry zero data and strobes so the IOb side sees a clean read
    assign iob_valid_o  = (r_state == S_WR_REQ) | (r_state == S_RD_REQ);
    assign iob_addr_o   = (r_state == S_WR_REQ) ? r_aw_addr : r_ar_addr;
    assign iob_wdata_o  = (r_state == S_WR_REQ) ? r_w_data : '0;
    assign iob_wstrb_o  = (r_state == S_WR_REQ) ? r_w_strb : '0;
    assign iob_rready_o = (r_state == S_RD_WAIT);

endmodule

// File: tb/tb_iob_axil2iob.sv
// Directed bench for iob_axil2iob: transaction-level reference model checked every
// cycle, an IOb target with programmable read delay, and literal expectations.
module tb_iob_axil2iob;

    logic        clk_i = 1'b0;
    logic        cke_i, arst_i;
    logic [31:0] axil_awaddr_i, axil_wdata_i, axil_araddr_i;
    logic [3:0]  axil_wstrb_i;
    logic        axil_awvalid_i, axil_wvalid_i, axil_arvalid_i, axil_bready_i, axil_rready_i;
    logic        axil_awready_o, axil_wready_o, axil_arready_o, axil_bvalid_o, axil_rvalid_o;
    logic [1:0]  axil_bresp_o, axil_rresp_o;
    logic [31:0] axil_rdata_o;
    logic        iob_valid_o, iob_rready_o, iob_ready_i;
    logic [31:0] iob_addr_o, iob_wdata_o, iob_rdata_i;
    logic [3:0]  iob_wstrb_o;
    wire         iob_rvalid_i;

    logic        tgt_rv, stray_rv;
    int          tgt_delay, tgt_cnt;
    logic [31:0] tgt_pend;
    logic [31:0] mem [logic [31:0]];
    logic [32:0] iob_log [$];

    int n_err = 0;
    int n_chk = 0;

    assign iob_rvalid_i = tgt_rv | stray_rv;

    iob_axil2iob #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .axil_awaddr_i(axil_awaddr_i), .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
        .axil_wdata_i(axil_wdata_i), .axil_wstrb_i(axil_wstrb_i), .axil_wvalid_i(axil_wvalid_i),
        .axil_wready_o(axil_wready_o), .axil_bresp_o(axil_bresp_o), .axil_bvalid_o(axil_bvalid_o),
        .axil_bready_i(axil_bready_i), .axil_araddr_i(axil_araddr_i), .axil_arvalid_i(axil_arvalid_i),
        .axil_arready_o(axil_arready_o), .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o),
        .axil_rvalid_o(axil_rvalid_o), .axil_rready_i(axil_rready_i),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i), .iob_rready_o(iob_rready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered AW/W/AR plus one operation in flight (none/write/read)
    logic        m_aw_full, m_w_full, m_ar_full, m_issued, m_have_resp, m_prefer_wr;
    logic [31:0] m_aw_addr, m_ar_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    int          m_op;   // 0 none, 1 write, 2 read

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            m_aw_full <= 1'b0; m_w_full <= 1'b0; m_ar_full <= 1'b0;
            m_issued <= 1'b0; m_have_resp <= 1'b0; m_prefer_wr <= 1'b1; m_op <= 0;
            m_aw_addr <= 32'h0; m_ar_addr <= 32'h0; m_wdata <= 32'h0; m_wstrb <= 4'h0; m_rdata <= 32'h0;
        end else if (cke_i) begin
            if (axil_awvalid_i && !m_aw_full) begin m_aw_full <= 1'b1; m_aw_addr <= axil_awaddr_i; end
            if (axil_wvalid_i && !m_w_full) begin m_w_full <= 1'b1; m_wdata <= axil_wdata_i; m_wstrb <= axil_wstrb_i; end
            if (axil_arvalid_i && !m_ar_full) begin m_ar_full <= 1'b1; m_ar_addr <= axil_araddr_i; end
            if (m_op == 0) begin
                if (m_aw_full && m_w_full && (!m_ar_full || m_prefer_wr)) begin
                    m_op <= 1; m_prefer_wr <= 1'b0;
                end else if (m_ar_full) begin
                    m_op <= 2; m_prefer_wr <= 1'b1;
                end
            end else if (!m_issued) begin
                if (iob_ready_i) begin
                    m_issued <= 1'b1;
                    if (m_op == 1) begin m_aw_full <= 1'b0; m_w_full <= 1'b0; end
                    else m_ar_full <= 1'b0;
                end
            end else if (m_op == 1) begin
                if (axil_bready_i) begin m_op <= 0; m_issued <= 1'b0; end
            end else if (!m_have_resp) begin
                if (iob_rvalid_i) begin m_have_resp <= 1'b1; m_rdata <= iob_rdata_i; end
            end else if (axil_rready_i) begin
                m_op <= 0; m_issued <= 1'b0; m_have_resp <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_i) begin
        check("m_awready", axil_awready_o, !m_aw_full);
        check("m_wready", axil_wready_o, !m_w_full);
        check("m_arready", axil_arready_o, !m_ar_full);
        check("m_iob_valid", iob_valid_o, (m_op != 0) && !m_issued);
        if ((m_op != 0) && !m_issued) begin
            check("m_iob_addr", iob_addr_o, (m_op == 1) ? m_aw_addr : m_ar_addr);
            check("m_iob_wstrb", iob_wstrb_o, (m_op == 1) ? m_wstrb : 4'h0);
            if (m_op == 1) check("m_iob_wdata", iob_wdata_o, m_wdata);
        end
        check("m_iob_rready", iob_rready_o, (m_op == 2) && m_issued && !m_have_resp);
        check("m_bvalid", axil_bvalid_o, (m_op == 1) && m_issued);
        if ((m_op == 1) && m_issued) check("m_bresp", axil_bresp_o, 2'b00);
        check("m_rvalid", axil_rvalid_o, (m_op == 2) && m_have_resp);
        if ((m_op == 2) && m_have_resp) begin
            check("m_rdata", axil_rdata_o, m_rdata);
            check("m_rresp", axil_rresp_o, 2'b00);
        end
    end

    // IOb target: stores writes, answers reads tgt_delay cycles after acceptance, logs requests
    initial begin : target
        logic        acc, acc_wr;
        logic [31:0] acc_addr, acc_wdata;
        tgt_rv = 1'b0; tgt_cnt = 0; tgt_pend = 32'h0; iob_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            acc       = iob_valid_o & iob_ready_i & cke_i & ~arst_i;
            acc_wr    = (iob_wstrb_o != 4'h0);
            acc_addr  = iob_addr_o;
            acc_wdata = iob_wdata_o;
            @(posedge clk_i);
            #1;
            tgt_rv = 1'b0;
            if (acc) begin
                iob_log.push_back({acc_wr, acc_addr});
                if (acc_wr) mem[acc_addr] = acc_wdata;
                else begin
                    tgt_cnt  = tgt_delay;
                    tgt_pend = mem.exists(acc_addr) ? mem[acc_addr] : ~acc_addr;
                end
            end
            if (tgt_cnt > 0) begin
                tgt_cnt--;
                if (tgt_cnt == 0) begin tgt_rv = 1'b1; iob_rdata_i = tgt_pend; end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // which: 0 rvalid, 1 bvalid, 2 iob_valid, 3 awready
    task automatic wait_for(input int which, input int bound, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk_i);
            case (which)
                0: hit = axil_rvalid_o;
                1: hit = axil_bvalid_o;
                2: hit = iob_valid_o;
                default: hit = axil_awready_o;
            endcase
            if (!hit) tick();
        end
        check(name, hit, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, axil_awready_o, 1'b1);
        check({tag, "_wready"}, axil_wready_o, 1'b1);
        check({tag, "_arready"}, axil_arready_o, 1'b1);
        check({tag, "_bvalid"}, axil_bvalid_o, 1'b0);
        check({tag, "_rvalid"}, axil_rvalid_o, 1'b0);
        check({tag, "_iob_valid"}, iob_valid_o, 1'b0);
        check({tag, "_iob_rready"}, iob_rready_o, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        arst_i = 1'b1; cke_i = 1'b1; stray_rv = 1'b0;
        axil_awaddr_i = 32'h0; axil_awvalid_i = 1'b0; axil_wdata_i = 32'h0; axil_wstrb_i = 4'h0;
        axil_wvalid_i = 1'b0; axil_araddr_i = 32'h0; axil_arvalid_i = 1'b0;
        axil_bready_i = 1'b1; axil_rready_i = 1'b1; iob_ready_i = 1'b1; tgt_delay = 1;
        mem[32'h20] = 32'h1234_5678;
        tick(); tick();
        @(negedge clk_i); check_reset_outputs("rst");
        tick(); arst_i = 1'b0;
        tick();

        // 1: simultaneous AW+W, zero-wait target
        axil_awaddr_i = 32'h10; axil_awvalid_i = 1'b1;
        axil_wdata_i = 32'hDEAD_BEEF; axil_wstrb_i = 4'hF; axil_wvalid_i = 1'b1;
        tick(); axil_awvalid_i = 1'b0; axil_wvalid_i = 1'b0;
        @(negedge clk_i); check("t1_c1_iob_valid", iob_valid_o, 1'b0); check("t1_c1_awready", axil_awready_o, 1'b0);
        tick(); @(negedge clk_i);
        check("t1_c2_iob_valid", iob_valid_o, 1'b1); check("t1_addr", iob_addr_o, 32'h10);
        check("t1_wstrb", iob_wstrb_o, 4'hF); check("t1_wdata", iob_wdata_o, 32'hDEAD_BEEF);
        tick(); @(negedge clk_i); check("t1_c3_bvalid", axil_bvalid_o, 1'b1); check("t1_bresp", axil_bresp_o, 2'b00);
        tick(); @(negedge clk_i); check("t1_c4_bvalid", axil_bvalid_o, 1'b0);
        tick();

        // 2: read with 2-cycle IOb latency, initiator stalls rready for 3 cycles
        tgt_delay = 2; axil_rready_i = 1'b0;
        axil_araddr_i = 32'h20; axil_arvalid_i = 1'b1;
        tick(); axil_arvalid_i = 1'b0;
        @(negedge clk_i); check("t2_arready", axil_arready_o, 1'b0);
        tick(); @(negedge clk_i); check("t2_c2_iob_valid", iob_valid_o, 1'b1);
        check("t2_addr", iob_addr_o, 32'h20); check("t2_wstrb", iob_wstrb_o, 4'h0);
        tick(); @(negedge clk_i); check("t2_c3_iob_rready", iob_rready_o, 1'b1); check("t2_c3_rvalid", axil_rvalid_o, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk_i);
            check("t2_hold_rvalid", axil_rvalid_o, 1'b1); check("t2_hold_rdata", axil_rdata_o, 32'h1234_5678);
        end
        tick(); axil_rready_i = 1'b1;
        @(negedge clk_i); check("t2_c8_rvalid", axil_rvalid_o, 1'b1);
        tick(); @(negedge clk_i); check("t2_c9_rvalid", axil_rvalid_o, 1'b0);
        tick(); tgt_delay = 1;

        // 3: W three cycles ahead of AW
        axil_wdata_i = 32'hCAFE_F00D; axil_wstrb_i = 4'h3; axil_wvalid_i = 1'b1;
        tick(); axil_wvalid_i = 1'b0;
        @(negedge clk_i); check("t3_wready", axil_wready_o, 1'b0); check("t3_c1_iob_valid", iob_valid_o, 1'b0);
        tick(); @(negedge clk_i); check("t3_c2_iob_valid", iob_valid_o, 1'b0);
        tick(); axil_awaddr_i = 32'h30; axil_awvalid_i = 1'b1;
        @(negedge clk_i); check("t3_c3_iob_valid", iob_valid_o, 1'b0);
        tick(); axil_awvalid_i = 1'b0;
        @(negedge clk_i); check("t3_c4_iob_valid", iob_valid_o, 1'b0);
        tick();
        wait_for(2, 4, "t3_wait_iob_valid");
        check("t3_addr", iob_addr_o, 32'h30); check("t3_wdata", iob_wdata_o, 32'hCAFE_F00D); check("t3_wstrb", iob_wstrb_o, 4'h3);
        tick(); wait_for(1, 4, "t3_wait_bvalid");
        tick(); tick();

        // 5a: write request held while IOb stalls 5 cycles
        iob_ready_i = 1'b0;
        axil_awaddr_i = 32'h80; axil_awvalid_i = 1'b1;
        axil_wdata_i = 32'h5555_AAAA; axil_wstrb_i = 4'hF; axil_wvalid_i = 1'b1;
        tick(); axil_awvalid_i = 1'b0; axil_wvalid_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t5_stall_valid", iob_valid_o, 1'b1); check("t5_stall_addr", iob_addr_o, 32'h80);
            check("t5_stall_wdata", iob_wdata_o, 32'h5555_AAAA); check("t5_stall_awready", axil_awready_o, 1'b0);
            tick();
        end
        iob_ready_i = 1'b1;
        wait_for(1, 4, "t5_wait_bvalid");
        tick(); tick();

        // 5b: stalled read; one AW accepted, the next stalls until the buffer drains
        iob_log.delete();
        iob_ready_i = 1'b0; axil_araddr_i = 32'h90; axil_arvalid_i = 1'b1;
        tick(); axil_arvalid_i = 1'b0; axil_awaddr_i = 32'hA0; axil_awvalid_i = 1'b1;
        @(negedge clk_i); check("t5b_first_awready", axil_awready_o, 1'b1);
        tick(); axil_awaddr_i = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t5b_second_awready", axil_awready_o, 1'b0); check("t5b_rd_valid", iob_valid_o, 1'b1);
            check("t5b_rd_addr", iob_addr_o, 32'h90); check("t5b_rd_wstrb", iob_wstrb_o, 4'h0);
            tick();
        end
        iob_ready_i = 1'b1; axil_wdata_i = 32'h0BAD_F00D; axil_wstrb_i = 4'hF; axil_wvalid_i = 1'b1;
        tick(); axil_wvalid_i = 1'b0;
        wait_for(3, 10, "t5b_wait_awready");
        tick(); axil_awvalid_i = 1'b0; axil_wdata_i = 32'h600D_F00D; axil_wvalid_i = 1'b1;
        tick(); axil_wvalid_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t5b_log_size", iob_log.size(), 32'd3);
        if (iob_log.size() == 3) begin
            check("t5b_log0", iob_log[0], {1'b0, 32'h90});
            check("t5b_log1", iob_log[1], {1'b1, 32'hA0});
            check("t5b_log2", iob_log[2], {1'b1, 32'hA4});
        end
        check("t5b_mem_a0", mem.exists(32'hA0) ? mem[32'hA0] : 32'h0, 32'h0BAD_F00D);
        check("t5b_mem_a4", mem.exists(32'hA4) ? mem[32'hA4] : 32'h0, 32'h600D_F00D);

        // 6: reset pulse while waiting for read data, then stray rvalids
        tgt_delay = 4; axil_araddr_i = 32'hB0; axil_arvalid_i = 1'b1;
        tick(); axil_arvalid_i = 1'b0;
        tick(); tick();
        @(negedge clk_i); check("t6_in_rd_wait", iob_rready_o, 1'b1);
        tick(); arst_i = 1'b1;
        @(negedge clk_i); check_reset_outputs("t6_rst");
        tick(); arst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stray_rv = (i == 2);
            @(negedge clk_i);
            check("t6_no_rvalid", axil_rvalid_o, 1'b0); check("t6_no_rready", iob_rready_o, 1'b0);
            tick();
        end
        stray_rv = 1'b0; tgt_delay = 1;

        // 4: write+read contention twice after reset -> W, R, W, R
        iob_log.delete();
        for (int r = 0; r < 2; r++) begin
            axil_awaddr_i = (r == 0) ? 32'h40 : 32'h60; axil_awvalid_i = 1'b1;
            axil_wdata_i = (r == 0) ? 32'h1111_1111 : 32'h2222_2222; axil_wstrb_i = 4'hF; axil_wvalid_i = 1'b1;
            axil_araddr_i = (r == 0) ? 32'h50 : 32'h70; axil_arvalid_i = 1'b1;
            tick(); axil_awvalid_i = 1'b0; axil_wvalid_i = 1'b0; axil_arvalid_i = 1'b0;
            for (int i = 0; i < 12; i++) tick();
        end
        check("t4_log_size", iob_log.size(), 32'd4);
        if (iob_log.size() == 4) begin
            check("t4_order0", iob_log[0], {1'b1, 32'h40});
            check("t4_order1", iob_log[1], {1'b0, 32'h50});
            check("t4_order2", iob_log[2], {1'b1, 32'h60});
            check("t4_order3", iob_log[3], {1'b0, 32'h70});
        end

        // 7: clock enable low freezes a pending write in IDLE
        axil_awaddr_i = 32'hC0; axil_awvalid_i = 1'b1;
        axil_wdata_i = 32'h0102_0304; axil_wstrb_i = 4'hF; axil_wvalid_i = 1'b1;
        tick(); axil_awvalid_i = 1'b0; axil_wvalid_i = 1'b0; cke_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t7_frozen_valid", iob_valid_o, 1'b0); check("t7_frozen_awready", axil_awready_o, 1'b0);
            tick();
        end
        cke_i = 1'b1;
        @(negedge clk_i); check("t7_c4_valid", iob_valid_o, 1'b0);
        tick(); @(negedge clk_i);
        check("t7_c5_valid", iob_valid_o, 1'b1); check("t7_addr", iob_addr_o, 32'hC0);
        tick(); wait_for(1, 4, "t7_wait_bvalid");
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
